// File: rtl/out_port_pkg.sv
// Shared types and constants for the OUT-port serial transmitter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package out_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int WORD_W         = BITS_PER_BYTE * BYTES_PER_WORD;

endpackage

// File: rtl/io_fifo.sv
// Generic synchronous FIFO with a show-ahead head output.
// Latency: a push is visible at rdata one cycle later; pop takes effect at the edge.
// Backpressure: full blocks push unless a pop lands in the same cycle; pop on empty is ignored.
module io_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers run modulo 2*DEPTH; the extra MSB separates full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/out_port_tx.sv
// OUT-port transmitter: buffers 16-bit words and sends each as two 8N1 frames, low byte first.
// Latency: strobe in cycle N gives a start bit from cycle N+2; a word occupies 20*CLKS_PER_BIT cycles.
// Backpressure: none upstream; pushes into a full FIFO are dropped and flagged on sticky overflow.
module out_port_tx
    import out_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        outWrite,
    input  logic [15:0] outData,
    output logic        txd,
    output logic        busy,
    output logic        full,
    output logic        overflow
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(BITS_PER_BYTE);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IMAX = IW'(BITS_PER_BYTE - 1);

    tx_state_t       state;
    tx_state_t       state_n;
    logic            hb;
    logic            hb_n;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_n;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_n;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_n;
    logic [WORD_W-1:0] head;
    logic            txd_n;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;

    io_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (outWrite),
        .pop   (pop),
        .wdata (outData),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign full = fifo_full;
    assign busy = (state != IDLE) || !fifo_empty;

    // txd is registered from the next-state decision so the line changes on the same edge as the state.
    always_comb begin
        state_n = state;
        hb_n    = hb;
        idx_n   = idx;
        timer_n = timer;
        shreg_n = shreg;
        txd_n   = txd;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    hb_n    = 1'b0;
                    timer_n = '0;
                    state_n = START;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (timer == TMAX) begin
                    timer_n = '0;
                    idx_n   = '0;
                    state_n = DATA;
                    txd_n   = shreg[0];
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer == TMAX) begin
                    timer_n = '0;
                    // After eight shifts the high byte sits in shreg[7:0].
                    shreg_n = shreg >> 1;
                    if (idx == IMAX) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                        txd_n = shreg[1];
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer == TMAX) begin
                    timer_n = '0;
                    if (!hb) begin
                        hb_n    = 1'b1;
                        state_n = START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            hb       <= 1'b0;
            idx      <= '0;
            timer    <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            hb    <= hb_n;
            idx   <= idx_n;
            timer <= timer_n;
            shreg <= shreg_n;
            txd   <= txd_n;
            if (outWrite && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_tx.sv
// Directed bench for out_port_tx with a UART-decoding monitor and a byte scoreboard.
module tb_out_port_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3000;

    logic        clock;
    logic        reset;
    logic        outWrite;
    logic [15:0] outData;
    logic        txd;
    logic        busy;
    logic        full;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    int         gaps[$];
    int         cyc      = 0;
    int         last_end = 0;
    int         mon_cnt  = 0;
    bit         mon_busy = 0;
    bit         rst_seen = 0;
    logic [7:0] mon_byte;
    logic [7:0] exp_byte;
    logic       sb_empty;

    out_port_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .outWrite (outWrite),
        .outData  (outData),
        .txd      (txd),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [15:0] w, input bit exp_acc);
        outWrite = 1'b1;
        outData  = w;
        if (exp_acc) begin
            sb.push_back(w[7:0]);
            sb.push_back(w[15:8]);
        end
        @(negedge clock);
        outWrite = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(n < LIMIT), 32'd1);
    endtask

    // A sampled reset abandons any frame the monitor is decoding.
    always @(posedge clock) begin
        if (reset === 1'b0) rst_seen = 1'b1;
    end

    always @(negedge clock) begin
        cyc++;
        if (rst_seen) begin
            rst_seen = 1'b0;
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (txd === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                gaps.push_back(cyc - last_end - 1);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == CPB / 2) check("start_bit", 32'(txd), 32'd0);
            for (int i = 0; i < 8; i++) begin
                if (mon_cnt == CPB * (1 + i) + CPB / 2) mon_byte[i] = txd;
            end
            if (mon_cnt == 9 * CPB + CPB / 2) begin
                check("stop_bit", 32'(txd), 32'd1);
                sb_empty = (sb.size() == 0);
                exp_byte = sb_empty ? 8'h00 : sb.pop_front();
                check("rx_byte", {23'd0, sb_empty, mon_byte}, {24'd0, exp_byte});
            end
            if (mon_cnt == 10 * CPB - 1) begin
                mon_busy = 1'b0;
                last_end = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b0;
        outWrite = 1'b0;
        outData  = 16'h0000;
        tick(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick(2);

        // Single word: start bit visible two cycles after the strobe.
        push(16'hA53C, 1'b1);
        check("pre_start_txd", 32'(txd), 32'd1);
        check("pre_start_busy", 32'(busy), 32'd1);
        tick(1);
        check("start_edge", 32'(txd), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick(1);
        end
        // busy is first low in the 81st cycle counted from the first start-bit cycle.
        check("busy_hold", 32'(n), 32'd80);
        wait_drain("drain_single");

        // Back-to-back words: one idle cycle between words, none between bytes.
        gaps.delete();
        push(16'h0001, 1'b1);
        push(16'hFFFF, 1'b1);
        wait_drain("drain_b2b");
        check("b2b_frames", 32'(gaps.size()), 32'd4);
        check("b2b_byte_gap", 32'(gaps[1]), 32'd0);
        check("b2b_word_gap", 32'(gaps[2]), 32'd1);

        // Overflow: first word popped at once, next four fill the FIFO, sixth dropped.
        for (int i = 0; i < 6; i++) push(16'h1100 + 16'(i), (i < 5));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_drain("drain_ovf");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset glitch between edges must not disturb an in-flight word.
        push(16'h5A5A, 1'b1);
        tick(10);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clock);
        check("glitch_busy", 32'(busy), 32'd1);
        check("glitch_ovf", 32'(overflow), 32'd1);
        wait_drain("drain_glitch");

        reset = 1'b0;
        tick(1);
        check("rst2_ovf", 32'(overflow), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick(2);

        // Fill the FIFO, then push in the IDLE cycle where the FSM pops.
        for (int i = 0; i < 5; i++) push(16'h2200 + 16'(i), 1'b1);
        tick(77);
        check("pp_full_before", 32'(full), 32'd1);
        push(16'h22F0, 1'b1);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_full_after", 32'(full), 32'd1);
        wait_drain("drain_pushpop");

        // Reset during data bit 3 of the low byte (0x34 bit 3 is 0).
        push(16'h1234, 1'b0);
        push(16'h5678, 1'b0);
        tick(17);
        check("mid_bit3", 32'(txd), 32'd0);
        reset = 1'b0;
        tick(1);
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_full", 32'(full), 32'd0);
        reset = 1'b1;
        tick(3);
        check("midrst_empty", 32'(busy), 32'd0);
        check("midrst_idle_txd", 32'(txd), 32'd1);
        push(16'h00FF, 1'b1);
        wait_drain("drain_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
